// File: rtl/mod_7seg_scan.sv
// Binary-to-BCD display driver: double-dabble conversion, leading-zero
// blanking and time-multiplexed digit scan onto a shared 4-bit bus.
module mod_7seg_scan #(
    parameter int N_DIGITS  = 4,
    parameter int BIN_WIDTH = 14,
    parameter int SCAN_DIV  = 1000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [BIN_WIDTH-1:0] i_value,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [3:0]           o_digit,
    output logic [N_DIGITS-1:0]  o_an,
    output logic                 o_overflow
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(N_DIGITS) - 64'd1;
    // Blank on every position except digit 0, which shows "0".
    localparam logic [BCD_W-1:0] DISP_RST = ~(BCD_W'(4'hF));

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_COMMIT
    } state_t;

    state_t               state_q;
    logic [BIN_WIDTH-1:0] value_q;
    logic [BIN_WIDTH-1:0] bin_q;
    logic [BCD_W-1:0]     bcd_q;
    logic [BCD_W-1:0]     bcd_adj;
    logic [BCD_W-1:0]     blanked;
    logic [BCD_W-1:0]     disp_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 cnt_last;
    logic                 too_big;

    logic [PRE_W-1:0]     pre_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_nxt;
    logic                 pre_wrap;
    logic                 idx_last;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Walk from the most significant nibble down, blanking until the
    // first non-zero digit is seen.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        blanked = bcd_q;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            if (!seen && i != 0) begin
                blanked[4*i +: 4] = 4'hF;
            end
        end
    end

    assign cnt_last = (cnt_q == CNT_W'(BIN_WIDTH - 1));
    assign too_big  = (64'(value_q) > MAX_VAL);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            o_ready    <= 1'b1;
            value_q    <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            disp_q     <= DISP_RST;
            o_overflow <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_valid && o_ready) begin
                        value_q <= i_value;
                        bin_q   <= i_value;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        o_ready <= 1'b0;
                        state_q <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_last) begin
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (too_big) begin
                        disp_q     <= '1;
                        o_overflow <= 1'b1;
                    end else begin
                        disp_q     <= blanked;
                        o_overflow <= 1'b0;
                    end
                    o_ready <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    o_ready <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pre_wrap = (pre_q == PRE_W'(SCAN_DIV - 1));
    assign idx_last = (idx_q == IDX_W'(N_DIGITS - 1));

    always_comb begin
        idx_nxt = idx_q;
        if (pre_wrap) begin
            idx_nxt = idx_last ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Enables and digit are loaded from the next index so both move
    // together on the prescaler wrap edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_q   <= '0;
            idx_q   <= '0;
            o_an    <= ~(N_DIGITS'(1));
            o_digit <= 4'h0;
        end else begin
            pre_q   <= pre_wrap ? '0 : pre_q + PRE_W'(1);
            idx_q   <= idx_nxt;
            o_an    <= ~(N_DIGITS'(1) << idx_nxt);
            o_digit <= disp_q[{idx_nxt, 2'b00} +: 4];
        end
    end

endmodule
